// File: rtl/multi_spike_source_pkg.sv
// Configuration packages for the stimulus source: network sizing, dispatch opcodes and
// the source-local slot layout and FSM state type.
package network_config;
  localparam int unsigned NUM_INP      = 5;
  localparam int unsigned CHARGE_WIDTH = 8;
endpackage

package dispatch_config;
  localparam int unsigned OPC_WIDTH = 3;
  localparam int unsigned NUM_OPC   = 4;
  // Encodings not listed here are accepted as no-ops.
  typedef enum logic [OPC_WIDTH-1:0] {
    OpcRun = 3'd1,
    OpcSpk = 3'd2,
    OpcSnc = 3'd3,
    OpcClr = 3'd4
  } opcode_t;
endpackage

package source_config;
  import network_config::*;
  import dispatch_config::*;

  localparam int unsigned PFX_WIDTH  = OPC_WIDTH;
  localparam int unsigned IDX_WIDTH  = (NUM_INP > 1) ? $clog2(NUM_INP) : 1;
  localparam int unsigned SLOT_WIDTH = 1 + IDX_WIDTH + CHARGE_WIDTH;

  typedef enum logic [1:0] {StIdle, StSpike, StRun, StSync} src_state_t;
endpackage

// File: rtl/multi_spike_source_sat_add.sv
// Signed adder that clamps to the representable range and flags when it clamped.
module sat_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_sum,
  output logic                    o_clamp
);
  logic signed [WIDTH:0] w_sum;

  assign w_sum   = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
  // Top two bits disagree exactly when the sum left the WIDTH-bit range.
  assign o_clamp = w_sum[WIDTH] ^ w_sum[WIDTH-1];

  always_comb begin
    o_sum = w_sum[WIDTH-1:0];
    if (o_clamp) begin
      o_sum = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
endmodule

// File: rtl/multi_spike_source.sv
// Packet-driven stimulus source: decodes RUN/SPK/SNC/CLR packets and drives the network
// core's enable, sync, reset and input-charge vector.
module multi_spike_source
  import network_config::*;
  import dispatch_config::*;
  import source_config::*;
#(
  parameter int unsigned SPK_PER_PKT = 2,
  parameter bit          ACCUM       = 1'b0,
  parameter int unsigned PKT_WIDTH   = PFX_WIDTH + SPK_PER_PKT * SLOT_WIDTH
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic [PKT_WIDTH-1:0]           src,
  input  logic                           net_ready,
  output logic                           net_sync,
  output logic                           net_arstn,
  output logic                           net_en,
  output logic signed [CHARGE_WIDTH-1:0] net_inp [NUM_INP],
  output logic                           overflow
);
  localparam int unsigned RUN_WIDTH = PKT_WIDTH - PFX_WIDTH;
  localparam int unsigned SLOTS_W   = SPK_PER_PKT * SLOT_WIDTH;
  localparam int unsigned PTR_W     = (SPK_PER_PKT > 1) ? $clog2(SPK_PER_PKT) : 1;
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(SPK_PER_PKT - 1);
  localparam logic [IDX_WIDTH:0]   NUM_INP_W = (IDX_WIDTH + 1)'(NUM_INP);

  if (PKT_WIDTH < PFX_WIDTH + SLOTS_W) begin : g_cfg_check
    $error("PKT_WIDTH too narrow for SPK_PER_PKT slots plus opcode");
  end

  src_state_t                     r_state, w_state_nxt;
  logic [RUN_WIDTH-1:0]           r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]               r_ptr, w_ptr_nxt;
  logic [SLOTS_W-1:0]             r_slots, w_slots_nxt;
  logic                           r_sync, w_sync_nxt;
  logic                           r_narst, w_narst_nxt;
  logic                           r_ovf;
  logic signed [CHARGE_WIDTH-1:0] r_inp [NUM_INP];
  logic                           w_clr;

  logic [PFX_WIDTH-1:0]           w_opc;
  logic [RUN_WIDTH-1:0]           w_run_n;
  logic [SLOT_WIDTH-1:0]          w_slot;
  logic                           w_slot_vld;
  logic [IDX_WIDTH-1:0]           w_slot_idx;
  logic signed [CHARGE_WIDTH-1:0] w_slot_val;
  logic signed [CHARGE_WIDTH-1:0] w_sum;
  logic                           w_clamp;
  logic                           w_wr;
  logic signed [CHARGE_WIDTH-1:0] w_wr_val;

  assign w_opc   = src[PKT_WIDTH-1 -: PFX_WIDTH];
  assign w_run_n = src[RUN_WIDTH-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_slots_nxt = r_slots;
    w_sync_nxt  = r_sync;
    w_narst_nxt = 1'b1;
    w_clr       = 1'b0;
    src_ready   = 1'b0;
    net_en      = 1'b0;
    unique case (r_state)
      StIdle: src_ready = 1'b1;
      StSpike: begin
        src_ready = (r_ptr == PTR_LAST);
        if (r_ptr == PTR_LAST) w_state_nxt = StIdle;
        else                   w_ptr_nxt   = r_ptr + 1'b1;
      end
      StRun: begin
        net_en    = net_ready;
        src_ready = net_ready && (r_cnt == RUN_WIDTH'(1));
        if (net_ready) begin
          w_cnt_nxt = r_cnt - RUN_WIDTH'(1);
          if (r_cnt == RUN_WIDTH'(1)) w_state_nxt = StIdle;
        end
      end
      StSync: begin
        src_ready = net_ready;
        if (net_ready) begin
          w_sync_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // An accepted packet dispatches identically from every state.
    if (src_valid && src_ready) begin
      w_state_nxt = StIdle;
      case (w_opc)
        OpcSpk: begin
          w_slots_nxt = src[SLOTS_W-1:0];
          w_ptr_nxt   = '0;
          w_state_nxt = StSpike;
        end
        OpcRun: begin
          if (w_run_n != '0) begin
            w_cnt_nxt   = w_run_n;
            w_state_nxt = StRun;
          end
        end
        OpcSnc: begin
          w_sync_nxt  = 1'b1;
          w_state_nxt = StSync;
        end
        OpcClr: begin
          w_narst_nxt = 1'b0;
          w_clr       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_slots <= '0;
      r_sync  <= 1'b0;
      r_narst <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_slots <= w_slots_nxt;
      r_sync  <= w_sync_nxt;
      r_narst <= w_narst_nxt;
    end
  end

  assign w_slot     = r_slots[r_ptr * SLOT_WIDTH +: SLOT_WIDTH];
  assign w_slot_vld = w_slot[SLOT_WIDTH-1];
  assign w_slot_idx = w_slot[CHARGE_WIDTH +: IDX_WIDTH];
  assign w_slot_val = w_slot[CHARGE_WIDTH-1:0];
  assign w_wr       = (r_state == StSpike) && w_slot_vld && ({1'b0, w_slot_idx} < NUM_INP_W);

  sat_add #(
    .WIDTH (CHARGE_WIDTH)
  ) u_sat_add (
    .i_a     (r_inp[w_slot_idx]),
    .i_b     (w_slot_val),
    .o_sum   (w_sum),
    .o_clamp (w_clamp)
  );

  assign w_wr_val = ACCUM ? w_sum : w_slot_val;

  // Charges are consumed by a timestep; CLR wins over a coincident final slot write.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_inp <= '{default: '0};
      r_ovf <= 1'b0;
    end else if (w_clr || net_en) begin
      r_inp <= '{default: '0};
      if (w_clr) r_ovf <= 1'b0;
    end else if (w_wr) begin
      r_inp[w_slot_idx] <= w_wr_val;
      if (ACCUM && w_clamp) r_ovf <= 1'b1;
    end
  end

  assign net_inp   = r_inp;
  assign net_sync  = r_sync;
  assign net_arstn = r_narst;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_multi_spike_source.sv
// Directed bench: an accumulating and an overwriting source share one stimulus stream.
module tb_multi_spike_source;
  localparam int unsigned PW = 32;
  localparam int unsigned NI = 5;
  localparam int unsigned NV = 26;

  logic clk = 1'b0;
  logic arstn, src_valid, net_ready;
  logic [PW-1:0] src;
  logic rdy_a, rdy_o, en_a, en_o, sync_a, sync_o, narst_a, narst_o, ovf_a, ovf_o;
  logic signed [7:0] inp_a [NI];
  logic signed [7:0] inp_o [NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_spike_source #(.SPK_PER_PKT(2), .ACCUM(1'b1), .PKT_WIDTH(PW)) u_acc (
    .clk(clk), .arstn(arstn), .src_valid(src_valid), .src_ready(rdy_a), .src(src),
    .net_ready(net_ready), .net_sync(sync_a), .net_arstn(narst_a), .net_en(en_a),
    .net_inp(inp_a), .overflow(ovf_a)
  );

  multi_spike_source #(.SPK_PER_PKT(2), .ACCUM(1'b0), .PKT_WIDTH(PW)) u_ovr (
    .clk(clk), .arstn(arstn), .src_valid(src_valid), .src_ready(rdy_o), .src(src),
    .net_ready(net_ready), .net_sync(sync_o), .net_arstn(narst_o), .net_en(en_o),
    .net_inp(inp_o), .overflow(ovf_o)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pkt;
    logic        nrdy;
    logic        rdy;
    logic        en;
    logic        sync;
    logic        narst;
    logic [39:0] acc;
    logic [39:0] ovr;
    logic        ovfa;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [31:0] spk(input logic v0, input logic [2:0] i0, input logic [7:0] d0,
                                      input logic v1, input logic [2:0] i1, input logic [7:0] d1);
    return {3'd2, 5'b10110, v1, i1, d1, v0, i0, d0};
  endfunction

  function automatic logic [31:0] run_pkt(input int n);
    return {3'd1, 29'(n)};
  endfunction

  task automatic chk(input string name, input int row, input logic [39:0] got,
                     input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic check_state(input int r, input logic rdy, input logic en, input logic sync,
                             input logic narst, input logic [39:0] acc, input logic [39:0] ovr,
                             input logic ovfa);
    logic [39:0] pa, po;
    for (int i = 0; i < NI; i++) begin
      pa[i*8 +: 8] = inp_a[i];
      po[i*8 +: 8] = inp_o[i];
    end
    chk("src_ready_acc", r, 40'(rdy_a), 40'(rdy));
    chk("src_ready_ovr", r, 40'(rdy_o), 40'(rdy));
    chk("net_en_acc", r, 40'(en_a), 40'(en));
    chk("net_en_ovr", r, 40'(en_o), 40'(en));
    chk("net_sync_acc", r, 40'(sync_a), 40'(sync));
    chk("net_sync_ovr", r, 40'(sync_o), 40'(sync));
    chk("net_arstn_acc", r, 40'(narst_a), 40'(narst));
    chk("net_arstn_ovr", r, 40'(narst_o), 40'(narst));
    chk("net_inp_acc", r, pa, acc);
    chk("net_inp_ovr", r, po, ovr);
    chk("overflow_acc", r, 40'(ovf_a), 40'(ovfa));
    chk("overflow_ovr", r, 40'(ovf_o), 40'd0);
  endtask

  task automatic run_vec(input int r, input vec_t v);
    @(negedge clk);
    src_valid = v.vld;
    src       = v.pkt;
    net_ready = v.nrdy;
    #1;
    check_state(r, v.rdy, v.en, v.sync, v.narst, v.acc, v.ovr, v.ovfa);
  endtask

  initial begin
    logic [31:0] p1, p2, p3, snc, clr, unk;
    logic [39:0] a64, a7f, a32, afd, a7fd;
    p1   = spk(1'b1, 3'd2, 8'd100, 1'b1, 3'd2, 8'd50);
    p2   = spk(1'b0, 3'd1, 8'd9, 1'b1, 3'd5, 8'd9);
    p3   = spk(1'b1, 3'd0, 8'hFD, 1'b1, 3'd4, 8'd7);
    snc  = {3'd3, 29'd0};
    clr  = {3'd4, 29'h0ABC};
    unk  = {3'd0, 29'h1234};
    a64  = 40'h0000640000;
    a7f  = 40'h00007F0000;
    a32  = 40'h0000320000;
    afd  = 40'h00000000FD;
    a7fd = 40'h07000000FD;

    //          vld   pkt         nrdy  rdy   en    sync  narst acc   ovr   ovfa
    vecs[0]  = '{1'b1, p1,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b0};
    vecs[1]  = '{1'b0, '0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b0};
    vecs[2]  = '{1'b0, '0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a64,  a64,  1'b0};
    vecs[3]  = '{1'b1, p2,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a7f,  a32,  1'b1};
    vecs[4]  = '{1'b0, '0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a7f,  a32,  1'b1};
    vecs[5]  = '{1'b0, '0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a7f,  a32,  1'b1};
    vecs[6]  = '{1'b1, run_pkt(3), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a7f,  a32,  1'b1};
    vecs[7]  = '{1'b0, '0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a7f,  a32,  1'b1};
    vecs[8]  = '{1'b0, '0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b1};
    vecs[9]  = '{1'b0, '0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0,   '0,   1'b1};
    vecs[10] = '{1'b1, run_pkt(2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0,   '0,   1'b1};
    vecs[11] = '{1'b0, '0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0,   '0,   1'b1};
    vecs[12] = '{1'b0, '0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0,   '0,   1'b1};
    vecs[13] = '{1'b1, snc,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b1};
    for (int i = 14; i < 18; i++) begin
      vecs[i] = '{1'b1, p3,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0,   '0,   1'b1};
    end
    vecs[18] = '{1'b1, p3,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, '0,   '0,   1'b1};
    vecs[19] = '{1'b0, '0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b1};
    vecs[20] = '{1'b0, '0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, afd,  afd,  1'b1};
    vecs[21] = '{1'b1, clr,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a7fd, a7fd, 1'b1};
    vecs[22] = '{1'b0, '0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0,   '0,   1'b0};
    vecs[23] = '{1'b1, run_pkt(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b0};
    vecs[24] = '{1'b1, unk,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b0};
    vecs[25] = '{1'b0, '0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0,   '0,   1'b0};

    // Reset held with the network ready, then released away from the clock edge.
    arstn     = 1'b0;
    src_valid = 1'b0;
    src       = '0;
    net_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_state(100, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    arstn = 1'b1;
    #1;
    check_state(101, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    check_state(102, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);

    for (int r = 0; r < NV; r++) run_vec(r, vecs[r]);

    // Asynchronous reset in the middle of a long RUN.
    @(negedge clk);
    src_valid = 1'b1;
    src       = run_pkt(10);
    net_ready = 1'b1;
    #1;
    check_state(200, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    @(negedge clk);
    src_valid = 1'b0;
    #1;
    check_state(201, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    check_state(202, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    arstn = 1'b0;
    #1;
    check_state(203, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    arstn = 1'b1;
    #1;
    check_state(204, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    check_state(205, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
